// File: rtl/ether_frame_rx_buffer_if.sv
// GMII receive pins plus the oldest-frame read port of the frame buffer.
// The master side is the PHY and frame consumer; the slave side is the buffer.
interface ether_frame_rx_buffer_if #(
  parameter int ADDR_W = 11
);
  logic              phy_rx_dv;
  logic              phy_rx_er;
  logic [7:0]        phy_rx_data;
  logic              frame_valid;
  logic [ADDR_W:0]   frame_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_release;

  modport master (
    output phy_rx_dv, phy_rx_er, phy_rx_data, rd_addr, frame_release,
    input  frame_valid, frame_len, rd_data
  );

  modport slave (
    input  phy_rx_dv, phy_rx_er, phy_rx_data, rd_addr, frame_release,
    output frame_valid, frame_len, rd_data
  );
endinterface

// File: rtl/ether_frame_rx_buffer.sv
// GMII frame capture: strips preamble/SFD, checks length and FCS, and stores
// good frames in a ring of slots read back oldest-first through a byte port.
module ether_frame_rx_buffer #(
  parameter int ADDR_W    = 11,
  parameter int SLOT_W    = 1,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter bit STRIP_FCS = 1'b1
) (
  input  logic                         phy_rx_clk,
  input  logic                         rst_n,
  ether_frame_rx_buffer_if.slave       bus,
  output logic [15:0]                  cnt_good,
  output logic [15:0]                  cnt_crc_err,
  output logic [15:0]                  cnt_len_err,
  output logic [15:0]                  cnt_drop
);

  localparam int SLOTS = 2 ** SLOT_W;
  localparam int GIANT = MAX_LEN + 1;
  localparam logic [SLOT_W:0] FULL    = (SLOT_W + 1)'(SLOTS);
  localparam logic [ADDR_W:0] MIN_L   = (ADDR_W + 1)'(MIN_LEN);
  localparam logic [ADDR_W:0] GIANT_L = (ADDR_W + 1)'(GIANT);
  localparam logic [ADDR_W:0] FCS_L   = (ADDR_W + 1)'(4);
  localparam logic [31:0]     RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t            state;
  logic [2:0]        pre_cnt;
  logic [ADDR_W:0]   ptr;
  logic [31:0]       crc;
  logic [SLOT_W-1:0] wr_slot;
  logic [SLOT_W-1:0] rd_slot;
  logic [SLOT_W:0]   occupancy;
  logic [ADDR_W:0]   slot_len [SLOTS];
  logic [7:0]        mem [SLOTS * (2 ** ADDR_W)];

  logic              mem_we;
  logic              commit;
  logic              release_ok;
  logic [ADDR_W:0]   commit_len;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mem_we     = (state == DATA) && bus.phy_rx_dv;
  assign release_ok = bus.frame_release && (occupancy != '0);
  assign commit     = (state == DATA) && !bus.phy_rx_dv && (ptr >= MIN_L) && (crc == RESIDUE);
  assign commit_len = STRIP_FCS ? (ptr - FCS_L) : ptr;

  // Frame memory has no reset; only the slot being filled is ever written.
  always_ff @(posedge phy_rx_clk) begin
    if (mem_we) begin
      mem[{wr_slot, ptr[ADDR_W-1:0]}] <= bus.phy_rx_data;
    end
  end

  always_ff @(posedge phy_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pre_cnt         <= '0;
      ptr             <= '0;
      crc             <= '1;
      wr_slot         <= '0;
      rd_slot         <= '0;
      occupancy       <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_len   <= '0;
      bus.rd_data     <= '0;
      cnt_good        <= '0;
      cnt_crc_err     <= '0;
      cnt_len_err     <= '0;
      cnt_drop        <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_len[s] <= '0;
      end
    end else begin
      // Read-side outputs follow the registered ring state, one edge behind it.
      bus.frame_valid <= (occupancy != '0);
      bus.frame_len   <= slot_len[rd_slot];
      bus.rd_data     <= mem[{rd_slot, bus.rd_addr}];

      if (release_ok) begin
        rd_slot <= rd_slot + 1'b1;
      end
      if (commit && !release_ok) begin
        occupancy <= occupancy + 1'b1;
      end else if (!commit && release_ok) begin
        occupancy <= occupancy - 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.phy_rx_dv) begin
            if (bus.phy_rx_data == 8'h55) begin
              state   <= PRE;
              pre_cnt <= 3'd1;
            end else begin
              state <= DROP;
            end
          end
        end

        PRE: begin
          if (!bus.phy_rx_dv) begin
            state <= IDLE;
          end else if (bus.phy_rx_data == 8'h55) begin
            if (pre_cnt != 3'd7) begin
              pre_cnt <= pre_cnt + 3'd1;
            end
          end else if (bus.phy_rx_data == 8'hD5 && pre_cnt != 3'd0) begin
            if (occupancy == FULL) begin
              state    <= DROP;
              cnt_drop <= sat_inc(cnt_drop);
            end else begin
              state <= DATA;
              ptr   <= '0;
              crc   <= '1;
            end
          end else begin
            state <= DROP;
          end
        end

        DATA: begin
          if (bus.phy_rx_dv) begin
            ptr <= ptr + 1'b1;
            crc <= crc_byte(crc, bus.phy_rx_data);
            if (bus.phy_rx_er) begin
              state    <= DROP;
              cnt_drop <= sat_inc(cnt_drop);
            end else if (ptr + 1'b1 == GIANT_L) begin
              state       <= DROP;
              cnt_len_err <= sat_inc(cnt_len_err);
            end
          end else begin
            // End of frame: length first, then FCS residue, then commit.
            state <= IDLE;
            if (ptr < MIN_L) begin
              cnt_len_err <= sat_inc(cnt_len_err);
            end else if (crc != RESIDUE) begin
              cnt_crc_err <= sat_inc(cnt_crc_err);
            end else begin
              slot_len[wr_slot] <= commit_len;
              wr_slot           <= wr_slot + 1'b1;
              cnt_good          <= sat_inc(cnt_good);
            end
          end
        end

        DROP: begin
          if (!bus.phy_rx_dv) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_frame_rx_buffer.sv
// Self-checking bench for ether_frame_rx_buffer: a table of frame vectors plus
// hand-written ring-full, commit/release overlap and mid-frame reset sequences.
module tb_ether_frame_rx_buffer;

  localparam int ADDR_W = 11;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cnt_good, cnt_crc_err, cnt_len_err, cnt_drop;

  ether_frame_rx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  ether_frame_rx_buffer #(
    .ADDR_W(ADDR_W), .SLOT_W(1), .MIN_LEN(64), .MAX_LEN(1518), .STRIP_FCS(1'b1)
  ) dut (
    .phy_rx_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_good   (cnt_good),
    .cnt_crc_err(cnt_crc_err),
    .cnt_len_err(cnt_len_err),
    .cnt_drop   (cnt_drop)
  );

  always #4 clk = ~clk;

  typedef struct {
    int         rep_len;
    logic [7:0] seed;
  } exp_frame_t;

  typedef struct {
    string      name;
    int         len;
    logic [7:0] seed;
    int         flip_idx;
    int         er_idx;
    int         pre_len;
    logic [7:0] sfd;
    int         d_good;
    int         d_crc;
    int         d_len;
    int         d_drop;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  int         exp_good = 0, exp_crc = 0, exp_len = 0, exp_drop = 0;
  exp_frame_t sb_q[$];
  vec_t       vecs[12];
  logic [7:0] fbuf [0:2047];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string name);
    checkOutput({name, "_cnt_good"},    32'(cnt_good),    32'(exp_good));
    checkOutput({name, "_cnt_crc_err"}, 32'(cnt_crc_err), 32'(exp_crc));
    checkOutput({name, "_cnt_len_err"}, 32'(cnt_len_err), 32'(exp_len));
    checkOutput({name, "_cnt_drop"},    32'(cnt_drop),    32'(exp_drop));
  endtask

  task automatic push_expected(input int rep_len, input logic [7:0] seed);
    exp_frame_t e;
    e.rep_len = rep_len;
    e.seed    = seed;
    sb_q.push_back(e);
  endtask

  // Builds payload bytes seed+i, appends the Ethernet FCS, then drives the frame
  // followed by exactly one dv=0 cycle (optionally with frame_release on that edge).
  task automatic send_frame(input int len, input logic [7:0] seed, input int flip_idx,
                            input int er_idx, input int pre_len, input logic [7:0] sfd,
                            input bit rel_at_end);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      b = seed + i[7:0];
      fbuf[i] = b;
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    fbuf[len-4] = c[7:0];
    fbuf[len-3] = c[15:8];
    fbuf[len-2] = c[23:16];
    fbuf[len-1] = c[31:24];
    if (flip_idx >= 0) fbuf[flip_idx] = fbuf[flip_idx] ^ 8'h01;
    for (int p = 0; p < pre_len; p++) begin
      bus.phy_rx_dv   = 1'b1;
      bus.phy_rx_data = 8'h55;
      tick();
    end
    bus.phy_rx_dv   = 1'b1;
    bus.phy_rx_data = sfd;
    tick();
    for (int i = 0; i < len; i++) begin
      bus.phy_rx_data = fbuf[i];
      bus.phy_rx_er   = (i == er_idx);
      tick();
    end
    bus.phy_rx_dv     = 1'b0;
    bus.phy_rx_er     = 1'b0;
    bus.phy_rx_data   = 8'h00;
    bus.frame_release = rel_at_end;
    tick();
    bus.frame_release = 1'b0;
  endtask

  // Pops the scoreboard head, checks it against the oldest stored frame, releases it.
  task automatic consume(input string name);
    exp_frame_t e;
    int         n;
    int         addrs[3];
    logic [7:0] expb;
    n = 0;
    while (!bus.frame_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput({name, "_valid"}, 32'(bus.frame_valid), 32'd1);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard actual=empty expected=frame", name);
      return;
    end
    e = sb_q.pop_front();
    checkOutput({name, "_frame_len"}, 32'(bus.frame_len), 32'(e.rep_len));
    addrs[0] = 0;
    addrs[1] = 5;
    addrs[2] = e.rep_len - 1;
    for (int j = 0; j < 3; j++) begin
      bus.rd_addr = addrs[j][ADDR_W-1:0];
      tick();
      expb = e.seed + addrs[j][7:0];
      checkOutput($sformatf("%s_rd%0d", name, addrs[j]), 32'(bus.rd_data), 32'(expb));
    end
    bus.frame_release = 1'b1;
    tick();
    bus.frame_release = 1'b0;
    tick();
  endtask

  task automatic set_vec(input int idx, input string name, input int len, input logic [7:0] seed,
                         input int flip_idx, input int er_idx, input int pre_len,
                         input logic [7:0] sfd, input int dg, input int dc, input int dl,
                         input int dd);
    vecs[idx].name     = name;
    vecs[idx].len      = len;
    vecs[idx].seed     = seed;
    vecs[idx].flip_idx = flip_idx;
    vecs[idx].er_idx   = er_idx;
    vecs[idx].pre_len  = pre_len;
    vecs[idx].sfd      = sfd;
    vecs[idx].d_good   = dg;
    vecs[idx].d_crc    = dc;
    vecs[idx].d_len    = dl;
    vecs[idx].d_drop   = dd;
  endtask

  task automatic applyStimulus(input vec_t v);
    send_frame(v.len, v.seed, v.flip_idx, v.er_idx, v.pre_len, v.sfd, 1'b0);
    exp_good += v.d_good;
    exp_crc  += v.d_crc;
    exp_len  += v.d_len;
    exp_drop += v.d_drop;
    if (v.d_good != 0) begin
      push_expected(v.len - 4, v.seed);
      checkOutput({v.name, "_fv_commit_edge"}, 32'(bus.frame_valid), 32'd0);
      tick();
      checkOutput({v.name, "_fv_latency"}, 32'(bus.frame_valid), 32'd1);
      consume(v.name);
    end else begin
      tick();
      tick();
      tick();
      checkOutput({v.name, "_fv_low"}, 32'(bus.frame_valid), 32'd0);
    end
    check_counters(v.name);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.phy_rx_dv     = 1'b0;
    bus.phy_rx_er     = 1'b0;
    bus.phy_rx_data   = 8'h00;
    bus.rd_addr       = '0;
    bus.frame_release = 1'b0;

    //        name          len   seed   flip er  pre sfd    g  c  l  d
    set_vec(0,  "min_good",   64,  8'h00, -1, -1, 7, 8'hD5, 1, 0, 0, 0);
    set_vec(1,  "crc_err",    64,  8'h00, 10, -1, 7, 8'hD5, 0, 1, 0, 0);
    set_vec(2,  "giant1600",  1600, 8'h11, -1, -1, 7, 8'hD5, 0, 0, 1, 0);
    set_vec(3,  "runt40",     40,  8'h22, -1, -1, 7, 8'hD5, 0, 0, 1, 0);
    set_vec(4,  "bad_sfd",    64,  8'h33, -1, -1, 7, 8'h00, 0, 0, 0, 0);
    set_vec(5,  "rx_er",      64,  8'h44, -1, 20, 7, 8'hD5, 0, 0, 0, 1);
    set_vec(6,  "good100",    100, 8'h30, -1, -1, 7, 8'hD5, 1, 0, 0, 0);
    set_vec(7,  "max_len",    1518, 8'h55, -1, -1, 7, 8'hD5, 1, 0, 0, 0);
    set_vec(8,  "min_minus1", 63,  8'h66, -1, -1, 7, 8'hD5, 0, 0, 1, 0);
    set_vec(9,  "max_plus1",  1519, 8'h70, -1, -1, 7, 8'hD5, 0, 0, 1, 0);
    set_vec(10, "no_pre",     64,  8'h80, -1, -1, 0, 8'hD5, 0, 0, 0, 0);
    set_vec(11, "short_pre",  64,  8'h77, -1, -1, 1, 8'hD5, 1, 0, 0, 0);

    #1;
    checkOutput("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    checkOutput("rst_frame_len",   32'(bus.frame_len),   32'd0);
    checkOutput("rst_rd_data",     32'(bus.rd_data),     32'd0);
    check_counters("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
    end

    // Ring full: third frame has no slot; after one release a fourth fits.
    send_frame(64, 8'hA0, -1, -1, 7, 8'hD5, 1'b0);
    send_frame(64, 8'hB0, -1, -1, 7, 8'hD5, 1'b0);
    send_frame(64, 8'hC0, -1, -1, 7, 8'hD5, 1'b0);
    push_expected(60, 8'hA0);
    push_expected(60, 8'hB0);
    exp_good += 2;
    exp_drop += 1;
    tick();
    check_counters("ring_full");
    consume("ring_first");
    send_frame(64, 8'hD0, -1, -1, 7, 8'hD5, 1'b0);
    push_expected(60, 8'hD0);
    exp_good += 1;
    tick();
    check_counters("ring_refill");
    consume("ring_second");
    consume("ring_fourth");
    tick();
    checkOutput("ring_empty_fv", 32'(bus.frame_valid), 32'd0);

    // Commit and release on the same edge with one frame held.
    send_frame(64, 8'h10, -1, -1, 7, 8'hD5, 1'b0);
    push_expected(60, 8'h10);
    tick();
    checkOutput("cr_old_len", 32'(bus.frame_len), 32'd60);
    send_frame(80, 8'h20, -1, -1, 7, 8'hD5, 1'b1);
    void'(sb_q.pop_front());
    push_expected(76, 8'h20);
    exp_good += 2;
    tick();
    tick();
    checkOutput("cr_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("cr_new_len", 32'(bus.frame_len), 32'd76);
    bus.rd_addr = 11'd5;
    tick();
    checkOutput("cr_new_rd5", 32'(bus.rd_data), 32'h25);
    check_counters("cr");

    // Reset in the middle of a frame: everything clears at once.
    for (int p = 0; p < 7; p++) begin
      bus.phy_rx_dv   = 1'b1;
      bus.phy_rx_data = 8'h55;
      tick();
    end
    bus.phy_rx_data = 8'hD5;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.phy_rx_data = 8'h99;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    checkOutput("mid_rst_frame_len",   32'(bus.frame_len),   32'd0);
    checkOutput("mid_rst_rd_data",     32'(bus.rd_data),     32'd0);
    exp_good = 0;
    exp_crc  = 0;
    exp_len  = 0;
    exp_drop = 0;
    sb_q.delete();
    check_counters("mid_rst");
    bus.phy_rx_dv   = 1'b0;
    bus.phy_rx_data = 8'h00;
    bus.rd_addr     = '0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(64, 8'h60, -1, -1, 7, 8'hD5, 1'b0);
    push_expected(60, 8'h60);
    exp_good += 1;
    tick();
    checkOutput("post_rst_fv", 32'(bus.frame_valid), 32'd1);
    consume("post_rst");
    check_counters("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
